imem_loader: RTL and testbench

Boot-time program loader that fills the instruction memory from an external byte stream. Bytes arrive over a valid/ready handshake, are packed into 32-bit words, and are written to consecutive word-aligned byte addresses through a single-cycle write port. The loader is the write side of the instruction memory, whose fetch side is indexed by `address >> 2`. It holds the CPU while a load is in progress and flags completion.

---
 rtl/imem_loader_pkg.sv | 23 ++
 rtl/imem_loader_assembler.sv | 35 +++
 rtl/imem_loader.sv | 158 +++++++++++++++
 tb/tb_imem_loader.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared types and constants for the instruction-memory loader.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (adds the CKSUM state).
package imem_loader_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int          DEFAULT_DEPTH  = 256;

    // Width able to hold any word count from 0 to depth inclusive.
    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RECV,
        ST_WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CKSUM,
`endif
        ST_DONE
    } state_t;

endpackage

// File: rtl/imem_loader_assembler.sv
// byte_assembler: packs a big-endian byte stream into 32-bit words.
// Only the first three bytes are stored; the fourth is taken straight from
// the input so the full word is available in the cycle it completes.
module byte_assembler
    import imem_loader_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        shift,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        complete
);

    localparam int unsigned CNT_W = $clog2(BYTES_PER_WORD);

    logic [23:0]      shreg;
    logic [CNT_W-1:0] cnt;

    // Shift in accepted bytes and count position within the current word.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (shift) begin
            shreg <= {shreg[15:0], byte_in};
            cnt   <= cnt + CNT_W'(1);
        end
    end

    assign word     = {shreg, byte_in};
    assign complete = shift && (cnt == CNT_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-time loader filling instruction memory from a byte stream.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (trailing 32-bit checksum, err).
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [8:0]        num_words,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              cpu_hold,
    output logic              err
);

    localparam int unsigned CW = count_width(DEPTH);

    state_t        state;
    logic [CW-1:0] target;
    logic [CW-1:0] target_next;
    logic [CW-1:0] idx;
    logic [CW-1:0] idx_inc;
    logic          launch;
    logic          hs;
    logic [31:0]   asm_word;
    logic          asm_complete;

    assign launch   = start && (state == ST_IDLE || state == ST_DONE);
    assign hs       = byte_valid && byte_ready;
    assign idx_inc  = idx + CW'(1);
    assign cpu_hold = busy;

    // Word target is the requested count clamped to the memory depth.
    always_comb begin
        target_next = CW'(num_words);
        if (32'(num_words) > 32'(DEPTH)) target_next = CW'(DEPTH);
    end

    byte_assembler u_asm (
        .clock    (clock),
        .reset    (reset),
        .clear    (launch),
        .shift    (hs),
        .byte_in  (byte_data),
        .word     (asm_word),
        .complete (asm_complete)
    );

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] sum;
    logic        err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Load sequencer; every output is registered and set on state entry.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            target     <= '0;
            idx        <= '0;
            byte_ready <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum        <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            mem_we <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        target <= target_next;
                        idx    <= '0;
                        done   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        sum    <= '0;
                        err_q  <= 1'b0;
`endif
                        if (target_next == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state      <= ST_CKSUM;
                            busy       <= 1'b1;
                            byte_ready <= 1'b1;
`else
                            state      <= ST_DONE;
                            done       <= 1'b1;
`endif
                        end else begin
                            state      <= ST_RECV;
                            busy       <= 1'b1;
                            byte_ready <= 1'b1;
                        end
                    end
                end
                ST_RECV: begin
                    if (asm_complete) begin
                        state      <= ST_WRITE;
                        byte_ready <= 1'b0;
                        mem_we     <= 1'b1;
                        mem_addr   <= ADDR_W'(idx) * ADDR_W'(BYTES_PER_WORD);
                        mem_wdata  <= asm_word;
                    end
                end
                ST_WRITE: begin
                    idx <= idx_inc;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum <= sum + mem_wdata;
`endif
                    if (idx_inc == target) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state      <= ST_CKSUM;
                        byte_ready <= 1'b1;
`else
                        state      <= ST_DONE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
`endif
                    end else begin
                        state      <= ST_RECV;
                        byte_ready <= 1'b1;
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                ST_CKSUM: begin
                    if (asm_complete) begin
                        err_q      <= (asm_word != sum);
                        state      <= ST_DONE;
                        byte_ready <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                    end
                end
`endif
                default: begin
                    state      <= ST_IDLE;
                    byte_ready <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed and randomized loads checked against a byte-list model.
// Honours IMEM_LOADER_CHECKSUM_EN when defined for the build.
module tb_imem_loader;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [8:0]  num_words = '0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = '0;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        cpu_hold;
    logic        err;

    imem_loader #(.DEPTH(256), .ADDR_W(32)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .num_words  (num_words),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
        .cpu_hold   (cpu_hold),
        .err        (err)
    );

    always #5 clock = ~clock;

    int          cyc = 0;
    int          hs_cyc[$];
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int          wr_cyc[$];
    int          drop_cnt = 0;
    int          hold_bad = 0;
    logic [7:0]  stim[$];
    int          wr_base;
    int          hs_base;
    int          total = 0;
    int          bad = 0;

    always @(posedge clock) cyc++;

    // Observe the write port and handshakes away from the active edge.
    always @(negedge clock) begin
        if (byte_valid && byte_ready) hs_cyc.push_back(cyc);
        if (mem_we) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
            wr_cyc.push_back(cyc);
        end
        if (busy && !byte_ready && !mem_we) drop_cnt++;
        if (cpu_hold !== busy) hold_bad++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Big-endian word k of the stimulus, by plain arithmetic.
    function automatic logic [31:0] model_word(input int k);
        return 32'(stim[4*k]) * 32'h0100_0000 + 32'(stim[4*k+1]) * 32'h0001_0000
             + 32'(stim[4*k+2]) * 32'h0000_0100 + 32'(stim[4*k+3]);
    endfunction

    function automatic logic [31:0] stim_sum(input int m);
        logic [31:0] s = '0;
        for (int k = 0; k < m; k++) s += model_word(k);
        return s;
    endfunction

    function automatic int gap_for(input int mode);
        if (mode == 0) return 0;
        if (mode == 1) return 1;
        return int'($urandom_range(0, 2));
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && t < 50) begin
            @(posedge clock); #1; t++;
        end
        if (!byte_ready) check("ready_timeout", byte_ready, 1);
        @(posedge clock); #1;
        if (gap > 0) begin
            byte_valid = 1'b0;
            byte_data  = 8'($urandom);
            repeat (gap) begin @(posedge clock); #1; end
        end
    endtask

    task automatic pulse_start(input int n);
        num_words = 9'(n);
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic run_load(input int n, input int mode, input logic [31:0] cks);
        int m;
        int t;
        m = (n > 256) ? 256 : n;
        wr_base = wr_addr.size();
        hs_base = hs_cyc.size();
        pulse_start(n);
`ifdef IMEM_LOADER_CHECKSUM_EN
        check("busy_after_start", busy, 1);
        check("done_after_start", done, 0);
`else
        check("busy_after_start", busy, (m > 0) ? 1 : 0);
        check("done_after_start", done, (m == 0) ? 1 : 0);
`endif
        foreach (stim[i]) send_byte(stim[i], gap_for(mode));
`ifdef IMEM_LOADER_CHECKSUM_EN
        for (int j = 3; j >= 0; j--) send_byte(8'(cks >> (8 * j)), gap_for(mode));
`endif
        byte_valid = 1'b0;
        t = 0;
        while (!done && t < 200) begin
            @(posedge clock); #1; t++;
        end
        check("done_at_end", done, 1);
        check("busy_at_end", busy, 0);
        check("write_count", wr_addr.size() - wr_base, m);
        for (int k = 0; k < m; k++) begin
            if (wr_base + k < wr_addr.size()) begin
                check("write_addr", wr_addr[wr_base + k], 32'(4 * k));
                check("write_data", wr_data[wr_base + k], model_word(k));
            end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        check("err_flag", err, (stim_sum(m) != cks) ? 1 : 0);
`else
        check("err_flag", err, 0);
`endif
    endtask

    initial begin
        int n;
        int d0;

        // Reset values
        repeat (3) @(posedge clock);
        #1;
        check("rst_byte_ready", byte_ready, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cpu_hold", cpu_hold, 0);
        check("rst_err", err, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        reset = 1'b0;
        @(posedge clock); #1;

        // Two words, valid held high: 10-cycle inclusive span first handshake to last write
        stim = '{8'h8C, 8'h01, 8'h00, 8'h04, 8'h20, 8'h42, 8'h00, 8'h01};
        run_load(2, 0, 32'hAC43_0005);
        check("word0_const", (wr_data.size() > wr_base) ? wr_data[wr_base] : 32'hDEAD_BEEF, 32'h8C01_0004);
        check("word1_const", (wr_data.size() > wr_base + 1) ? wr_data[wr_base + 1] : 32'hDEAD_BEEF, 32'h2042_0001);
        if (wr_cyc.size() > wr_base && hs_cyc.size() > hs_base)
            check("hs_to_last_we", wr_cyc[wr_cyc.size() - 1] - hs_cyc[hs_base], 9);
        else
            check("hs_to_last_we", 32'hFFFF_FFFF, 9);

        // One word with byte_valid toggling; ready must not drop outside WRITE
        stim = {};
        repeat (4) stim.push_back(8'($urandom));
        d0 = drop_cnt;
        run_load(1, 1, stim_sum(1));
        check("ready_drop", drop_cnt - d0, 0);

        // Zero-word load
        stim = {};
        run_load(0, 0, 32'h0);
        repeat (5) begin @(posedge clock); #1; end
        check("zero_no_writes", wr_addr.size() - wr_base, 0);

        // Oversized request clamps at DEPTH
        stim = {};
        repeat (1024) stim.push_back(8'($urandom));
        run_load(300, 0, stim_sum(256));
        check("clamp_last_addr", (wr_addr.size() > 0) ? wr_addr[wr_addr.size() - 1] : 32'h0, 32'h0000_03FC);

        // Reset in the middle of a five-word load
        stim = {};
        repeat (20) stim.push_back(8'($urandom));
        wr_base = wr_addr.size();
        pulse_start(5);
        for (int i = 0; i < 14; i++) send_byte(stim[i], 0);
        byte_valid = 1'b1;
        check("pre_reset_writes", wr_addr.size() - wr_base, 3);
        reset = 1'b1;
        @(posedge clock); #1;
        check("mid_byte_ready", byte_ready, 0);
        check("mid_mem_we", mem_we, 0);
        check("mid_busy", busy, 0);
        check("mid_done", done, 0);
        check("mid_cpu_hold", cpu_hold, 0);
        check("mid_err", err, 0);
        check("mid_mem_addr", mem_addr, 0);
        check("mid_mem_wdata", mem_wdata, 0);
        reset = 1'b0;
        repeat (20) begin @(posedge clock); #1; end
        byte_valid = 1'b0;
        check("post_reset_writes", wr_addr.size() - wr_base, 3);
        stim = {};
        repeat (4) stim.push_back(8'($urandom));
        run_load(1, 0, stim_sum(1));

        // Randomized loads with random gaps and checksums
        for (int it = 0; it < 4; it++) begin
            n = int'($urandom_range(1, 6));
            stim = {};
            repeat (4 * n) stim.push_back(8'($urandom));
            run_load(n, 2, stim_sum(n) + 32'($urandom_range(0, 1)));
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Checksum match and mismatch on words 1 and 2
        stim = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02};
        run_load(2, 0, 32'h0000_0003);
        check("cks_match_err", err, 0);
        run_load(2, 0, 32'h0000_0004);
        check("cks_mismatch_err", err, 1);
`endif

        check("cpu_hold_tracks_busy", hold_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
